// File: rtl/pdm_mic_capture.sv
// PDM microphone receiver: mic clock generation, CIC decimation to PCM,
// and a sample FIFO read by PicoSoC over the iomem bus.
module pdm_mic_capture #(
   parameter int CLK_DIV    = 16,
   parameter int DECIMATION = 64,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        mic_clk,
   input  logic        pdm_in
);

   localparam int SB = 2 * $clog2(DECIMATION);
   localparam int W  = SB + 1;
   localparam int DW = $clog2(CLK_DIV);
   localparam int RW = $clog2(DECIMATION);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [RW-1:0] DEC_LAST = RW'(DECIMATION - 1);
   localparam logic [SB-1:0] PCM_MAX  = '1;
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DATA   = 2'd2;

   // clock generation / capture / CIC state
   logic [1:0]    sync_q, sync_d;
   logic          en_q, en_d;
   logic [DW-1:0] div_q, div_d;
   logic          mic_clk_q, mic_clk_d;
   logic [W-1:0]  i1_q, i1_d;
   logic [W-1:0]  i2_q, i2_d;
   logic [W-1:0]  d1_q, d1_d;
   logic [W-1:0]  d2_q, d2_d;
   logic [RW-1:0] dec_q, dec_d;
   logic [1:0]    warm_q, warm_d;
   logic          smp_vld_q, smp_vld_d;
   logic [SB-1:0] smp_q, smp_d;

   // FIFO and bus state
   logic [SB-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          ready_q, ready_d;
   logic [31:0]   rdata_q, rdata_d;

   // intermediate terms
   logic          tick;
   logic [W-1:0]  i1_n, i2_n, c1, y;
   logic [SB-1:0] y_cl;
   logic          accept, is_rd, empty, full;
   logic [1:0]    sel;
   logic [SB-1:0] head;
   logic [31:0]   rd_val;
   logic          pop, flush, ovf_clr, push_ok, drop, mem_we;
   logic          unused_bits;

   assign unused_bits = ^{iomem_addr[31:4], iomem_addr[1:0],
                          iomem_wstrb[3:2], iomem_wdata[31:9],
                          iomem_wdata[7:2]};

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign mic_clk     = mic_clk_q;

   // Divider, bit capture and CIC integrate/comb on each mic_clk period
   always_comb begin
      sync_d    = {sync_q[0], pdm_in};
      tick      = en_q && (div_q == DIV_LAST);
      i1_n      = i1_q + W'(sync_q[1]);
      i2_n      = i2_q + i1_n;
      c1        = i2_n - d1_q;
      y         = c1 - d2_q;
      y_cl      = y[W-1] ? PCM_MAX : y[SB-1:0];
      div_d     = '0;
      i1_d      = i1_q;
      i2_d      = i2_q;
      d1_d      = d1_q;
      d2_d      = d2_q;
      dec_d     = dec_q;
      warm_d    = warm_q;
      smp_vld_d = 1'b0;
      smp_d     = smp_q;
      if (!en_q) begin
         i1_d   = '0;
         i2_d   = '0;
         d1_d   = '0;
         d2_d   = '0;
         dec_d  = '0;
         warm_d = '0;
      end else begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) begin
            i1_d  = i1_n;
            i2_d  = i2_n;
            dec_d = dec_q + 1'b1;
            if (dec_q == DEC_LAST) begin
               d1_d  = i2_n;
               d2_d  = c1;
               smp_d = {~y_cl[SB-1], y_cl[SB-2:0]};
               if (warm_q == 2'd2) begin
                  smp_vld_d = 1'b1;
               end else begin
                  warm_d = warm_q + 1'b1;
               end
            end
         end
      end
      mic_clk_d = en_q && (div_d < DIV_HALF);
   end

   // Bus decode, register access and FIFO pointer/count update
   always_comb begin
      accept  = iomem_valid && !ready_q;
      sel     = iomem_addr[3:2];
      is_rd   = (iomem_wstrb == 4'b0000);
      empty   = (cnt_q == '0);
      full    = (cnt_q == CNT_FULL);
      head    = mem_q[rd_ptr_q];
      rd_val  = '0;
      case (sel)
         REG_CTRL:   rd_val = {31'b0, en_q};
         REG_STATUS: rd_val = {22'b0, empty, ovf_q, 8'(cnt_q)};
         REG_DATA:   rd_val = empty ? '0 : {{(32-SB){head[SB-1]}}, head};
         default:    rd_val = '0;
      endcase
      pop     = accept && is_rd && (sel == REG_DATA) && !empty;
      flush   = accept && (sel == REG_CTRL) && iomem_wstrb[0]
                && iomem_wdata[1];
      ovf_clr = accept && (sel == REG_STATUS) && iomem_wstrb[1]
                && iomem_wdata[8];
      en_d    = en_q;
      if (accept && (sel == REG_CTRL) && iomem_wstrb[0]) begin
         en_d = iomem_wdata[0];
      end
      push_ok = smp_vld_q && (!full || pop) && !flush;
      drop    = smp_vld_q && full && !pop && !flush;
      mem_we  = push_ok;
      ovf_d   = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + AW'(push_ok);
         rd_ptr_d = rd_ptr_q + AW'(pop);
         cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);
      end
      ready_d = accept;
      rdata_d = accept ? rd_val : '0;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '0;
         en_q      <= 1'b0;
         div_q     <= '0;
         mic_clk_q <= 1'b0;
         i1_q      <= '0;
         i2_q      <= '0;
         d1_q      <= '0;
         d2_q      <= '0;
         dec_q     <= '0;
         warm_q    <= '0;
         smp_vld_q <= 1'b0;
         smp_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         ready_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         sync_q    <= sync_d;
         en_q      <= en_d;
         div_q     <= div_d;
         mic_clk_q <= mic_clk_d;
         i1_q      <= i1_d;
         i2_q      <= i2_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
         dec_q     <= dec_d;
         warm_q    <= warm_d;
         smp_vld_q <= smp_vld_d;
         smp_q     <= smp_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
      end
   end

   // Sample storage; contents need no reset since count gates reads
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem_q[wr_ptr_q] <= smp_q;
      end
   end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Directed bench for pdm_mic_capture: register table, PCM levels,
// overflow/drain ordering, flush race, disable/re-enable and reset.
module tb_pdm_mic_capture;

   localparam logic [1:0] R_CTRL = 2'd0;
   localparam logic [1:0] R_STAT = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;
   localparam logic [1:0] R_RSV  = 2'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = 4'h0;
   logic [31:0] iomem_addr = 32'h0;
   logic [31:0] iomem_wdata = 32'h0;
   logic [31:0] iomem_rdata;
   logic        mic_clk;
   logic        pdm_in = 1'b0;
   logic        alt = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]  r;
      logic [3:0]  strb;
      logic [31:0] wd;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [14];

   pdm_mic_capture dut (
      .clk         (clk),
      .reset       (reset),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .mic_clk     (mic_clk),
      .pdm_in      (pdm_in)
   );

   always #5 clk = ~clk;

   always @(negedge mic_clk) begin
      if (alt) pdm_in = ~pdm_in;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus(input logic [1:0] r, input logic [3:0] strb,
                      input logic [31:0] wd, output logic [31:0] rd);
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = {28'h0, r, 2'b00};
      iomem_wstrb = strb;
      iomem_wdata = wd;
      @(posedge clk);
      #1;
      chk("bus_ready", {31'b0, iomem_ready}, 32'd1);
      rd = iomem_rdata;
      @(negedge clk);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      @(posedge clk);
      #1;
      chk("ready_drop", {31'b0, iomem_ready}, 32'd0);
   endtask

   task automatic rd_chk(input string name, input logic [1:0] r,
                         input logic [31:0] exp);
      logic [31:0] v;
      bus(r, 4'h0, 32'h0, v);
      chk(name, v, exp);
   endtask

   task automatic wr(input logic [1:0] r, input logic [3:0] strb,
                     input logic [31:0] wd);
      logic [31:0] v;
      bus(r, strb, wd, v);
   endtask

   task automatic mic_ones(input int n, output int ones);
      ones = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (mic_clk === 1'b1) ones++;
      end
   endtask

   initial begin
      logic [31:0] v;
      int ones;
      bit found;

      vt[0]  = '{R_CTRL, 4'h0, 32'h0,        1'b1, 32'h0};
      vt[1]  = '{R_STAT, 4'h0, 32'h0,        1'b1, 32'h200};
      vt[2]  = '{R_DATA, 4'h0, 32'h0,        1'b1, 32'h0};
      vt[3]  = '{R_RSV,  4'h0, 32'h0,        1'b1, 32'h0};
      vt[4]  = '{R_RSV,  4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
      vt[5]  = '{R_RSV,  4'h0, 32'h0,        1'b1, 32'h0};
      vt[6]  = '{R_DATA, 4'hF, 32'h123,      1'b0, 32'h0};
      vt[7]  = '{R_STAT, 4'h0, 32'h0,        1'b1, 32'h200};
      vt[8]  = '{R_CTRL, 4'h2, 32'h1,        1'b0, 32'h0};
      vt[9]  = '{R_CTRL, 4'h0, 32'h0,        1'b1, 32'h0};
      vt[10] = '{R_CTRL, 4'h1, 32'h2,        1'b0, 32'h0};
      vt[11] = '{R_CTRL, 4'h0, 32'h0,        1'b1, 32'h0};
      vt[12] = '{R_STAT, 4'h2, 32'h100,      1'b0, 32'h0};
      vt[13] = '{R_STAT, 4'h0, 32'h0,        1'b1, 32'h200};

      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_ready", {31'b0, iomem_ready}, 32'd0);
      chk("rst_rdata", iomem_rdata, 32'h0);
      chk("rst_mic_clk", {31'b0, mic_clk}, 32'd0);

      for (int i = 0; i < 14; i++) begin
         bus(vt[i].r, vt[i].strb, vt[i].wd, v);
         if (vt[i].chk) begin
            n_vec++;
            if (v !== vt[i].exp) begin
               n_err++;
               $display("FAIL vec[%0d]: got 0x%08h expected 0x%08h",
                        i, v, vt[i].exp);
            end
         end
      end
      mic_ones(40, ones);
      chk("idle_mic_clk", ones, 0);

      // all-ones stream
      pdm_in = 1'b1;
      wr(R_CTRL, 4'h1, 32'h1);
      rd_chk("ctrl_en", R_CTRL, 32'h1);
      mic_ones(32, ones);
      chk("mic_clk_duty", ones, 16);
      repeat (4300) @(posedge clk);
      rd_chk("ones_count", R_STAT, 32'h002);
      rd_chk("ones_data0", R_DATA, 32'h000007FF);
      rd_chk("ones_data1", R_DATA, 32'h000007FF);
      rd_chk("ones_empty", R_STAT, 32'h200);
      wr(R_CTRL, 4'h1, 32'h2);
      repeat (4) @(posedge clk);
      #1;
      chk("dis_mic_clk", {31'b0, mic_clk}, 32'd0);

      // 50% density, then all-zeros
      alt = 1'b1;
      wr(R_CTRL, 4'h1, 32'h1);
      repeat (4300) @(posedge clk);
      rd_chk("alt_data", R_DATA, 32'h00000000);
      wr(R_CTRL, 4'h1, 32'h2);
      alt = 1'b0;
      pdm_in = 1'b0;
      wr(R_CTRL, 4'h1, 32'h1);
      repeat (3400) @(posedge clk);
      rd_chk("zero_data", R_DATA, 32'hFFFFF800);
      rd_chk("zero_empty", R_STAT, 32'h200);

      // overflow: 10 positive samples then 10 negative ones
      wr(R_CTRL, 4'h1, 32'h2);
      pdm_in = 1'b1;
      wr(R_CTRL, 4'h1, 32'h1);
      repeat (12588) @(posedge clk);
      wr(R_CTRL, 4'h1, 32'h0);
      rd_chk("ovf_half", R_STAT, 32'h00A);
      pdm_in = 1'b0;
      wr(R_CTRL, 4'h1, 32'h1);
      repeat (12588) @(posedge clk);
      wr(R_CTRL, 4'h1, 32'h0);
      rd_chk("ovf_full", R_STAT, 32'h110);
      wr(R_STAT, 4'h2, 32'h100);
      rd_chk("ovf_clear", R_STAT, 32'h010);
      for (int i = 0; i < 16; i++) begin
         bus(R_DATA, 4'h0, 32'h0, v);
         n_vec++;
         if (v !== ((i < 10) ? 32'h000007FF : 32'hFFFFF800)) begin
            n_err++;
            $display("FAIL drain[%0d]: got 0x%08h expected 0x%08h", i, v,
                     (i < 10) ? 32'h000007FF : 32'hFFFFF800);
         end
      end
      rd_chk("drain_extra", R_DATA, 32'h0);
      rd_chk("drain_status", R_STAT, 32'h200);

      // flush colliding with a push
      pdm_in = 1'b1;
      wr(R_CTRL, 4'h1, 32'h1);
      repeat (3400) @(posedge clk);
      rd_chk("pre_flush", R_STAT, 32'h001);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (dut.smp_vld_q === 1'b1) found = 1'b1;
      end
      chk("flush_sync", {31'b0, found}, 32'd1);
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0;
      iomem_wstrb = 4'h1;
      iomem_wdata = 32'h3;
      @(posedge clk);
      #1;
      chk("flush_ready", {31'b0, iomem_ready}, 32'd1);
      @(negedge clk);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      rd_chk("flush_count", R_STAT, 32'h200);

      // disable mid-sample, then warm-up drop on re-enable
      repeat (2400) @(posedge clk);
      rd_chk("run_count", R_STAT, 32'h002);
      wr(R_CTRL, 4'h1, 32'h0);
      mic_ones(40, ones);
      chk("off_mic_clk", ones, 0);
      repeat (2000) @(posedge clk);
      rd_chk("off_count", R_STAT, 32'h002);
      wr(R_CTRL, 4'h1, 32'h1);
      repeat (2400) @(posedge clk);
      rd_chk("warm_count", R_STAT, 32'h002);
      repeat (1000) @(posedge clk);
      rd_chk("post_warm", R_STAT, 32'h003);
      rd_chk("post_data", R_DATA, 32'h000007FF);

      // reset during a pending access
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = {28'h0, R_STAT, 2'b00};
      iomem_wstrb = 4'h0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_pend_ready", {31'b0, iomem_ready}, 32'd0);
      chk("rst_mic", {31'b0, mic_clk}, 32'd0);
      @(negedge clk);
      iomem_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_after_ready", {31'b0, iomem_ready}, 32'd0);
      rd_chk("rst_status", R_STAT, 32'h200);
      rd_chk("rst_ctrl", R_CTRL, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
